// File: rtl/eth_pkg.sv
// Shared ethernet-path definitions: AXI-Stream widths, RX arbiter state,
// beat struct and ethertype constants used by the header parser.
package eth_pkg;
  localparam int AXIS_DATA_W = 64;
  localparam int AXIS_KEEP_W = 8;

  typedef enum logic {IDLE, FWD} arb_state_e;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] data;
    logic [AXIS_KEEP_W-1:0] keep;
    logic                   last;
  } axis_beat_t;

  localparam logic [15:0] ETHTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETHTYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETHTYPE_VLAN = 16'h8100;
  localparam logic [15:0] ETHTYPE_IPV6 = 16'h86DD;
endpackage

// File: rtl/eth_rx_port_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority encoder; picks the first requester
// at or after ptr, cyclically. Shared with the TX-side scheduler.
module rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    ptr,
  output logic [PORT_W-1:0]    idx,
  output logic                 any
);
  logic [PORT_W:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester wins last.
  always_comb begin
    idx  = '0;
    cand = '0;
    any  = |req;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (PORT_W+1)'(k);
      if (cand >= (PORT_W+1)'(NUM_PORTS)) cand = cand - (PORT_W+1)'(NUM_PORTS);
      if (req[cand[PORT_W-1:0]]) idx = cand[PORT_W-1:0];
    end
  end
endmodule

// File: rtl/eth_rx_port_arbiter.sv
// Frame-granular round-robin arbiter feeding one header parser from NUM_PORTS
// AXI-Stream RX ports. Define ETH_ARB_PKT_CNT_EN to add per-port frame counters.
module eth_rx_port_arbiter
  import eth_pkg::*;
#(
  parameter int NUM_PORTS     = 4,
  parameter int PORT_W        = $clog2(NUM_PORTS),
  parameter int MAX_PKT_BEATS = 256
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS*AXIS_DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_PORTS*AXIS_KEEP_W-1:0] s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]             s_axis_tlast,
  output logic [NUM_PORTS-1:0]             s_axis_tready,
  output logic [AXIS_DATA_W-1:0]           m_axis_tdata,
  output logic [AXIS_KEEP_W-1:0]           m_axis_tkeep,
  output logic                             m_axis_tvalid,
  output logic                             m_axis_tlast,
  input  logic                             m_axis_tready,
  output logic [PORT_W-1:0]                grant_port,
  output logic                             busy,
  output logic                             frame_start,
  output logic                             trunc_err
`ifdef ETH_ARB_PKT_CNT_EN
  ,
  output logic [NUM_PORTS*32-1:0]          pkt_count
`endif
);
  localparam int              CNT_W     = $clog2(MAX_PKT_BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_PKT_BEATS - 1);

  arb_state_e                  state_q, state_d;
  logic [PORT_W-1:0]           rr_ptr, pick_idx;
  logic                        pick_any;
  logic [CNT_W-1:0]            beat_cnt;
  axis_beat_t [NUM_PORTS-1:0]  in_beat;
  axis_beat_t                  sel_beat;
  logic                        at_limit, hs, eof;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign in_beat[i] = {s_axis_tdata[i*AXIS_DATA_W +: AXIS_DATA_W],
                         s_axis_tkeep[i*AXIS_KEEP_W +: AXIS_KEEP_W],
                         s_axis_tlast[i]};
    assign s_axis_tready[i] = busy && (grant_port == PORT_W'(i)) && m_axis_tready;
  end

  rr_pick #(.NUM_PORTS(NUM_PORTS), .PORT_W(PORT_W)) u_pick (
    .req (s_axis_tvalid),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Datapath is a pure mux off the registered grant; no extra pipeline stage.
  assign sel_beat      = in_beat[grant_port];
  assign busy          = (state_q == FWD);
  assign at_limit      = busy && (beat_cnt == LAST_BEAT);
  assign m_axis_tdata  = sel_beat.data;
  assign m_axis_tkeep  = sel_beat.keep;
  assign m_axis_tvalid = busy && s_axis_tvalid[grant_port];
  assign m_axis_tlast  = busy && (sel_beat.last || at_limit);
  assign hs            = m_axis_tvalid && m_axis_tready;
  assign eof           = hs && m_axis_tlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = FWD;
      FWD:     if (eof)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      grant_port  <= '0;
      beat_cnt    <= '0;
      frame_start <= 1'b0;
      trunc_err   <= 1'b0;
    end else begin
      frame_start <= (state_q == IDLE) && pick_any;
      // An end of frame without the source's tlast can only be the beat limit.
      trunc_err   <= eof && !sel_beat.last;
      if ((state_q == IDLE) && pick_any) grant_port <= pick_idx;
      if (eof) begin
        beat_cnt <= '0;
        rr_ptr   <= (grant_port == PORT_W'(NUM_PORTS - 1)) ? '0 : grant_port + 1'b1;
      end else if (hs) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

`ifdef ETH_ARB_PKT_CNT_EN
  logic [NUM_PORTS-1:0][31:0] pkt_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++)
        if (eof && (grant_port == PORT_W'(i))) pkt_cnt_q[i] <= pkt_cnt_q[i] + 32'd1;
    end
  end

  assign pkt_count = pkt_cnt_q;
`endif
endmodule

// File: tb/tb_eth_rx_port_arbiter.sv
// Directed bench for eth_rx_port_arbiter (4 ports, beat limit 5); the frame
// counter checks are active when ETH_ARB_PKT_CNT_EN is defined.
module tb_eth_rx_port_arbiter;
  localparam int NP   = 4;
  localparam int MAXB = 5;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NP*64-1:0]   s_tdata;
  logic [NP*8-1:0]    s_tkeep;
  logic [NP-1:0]      s_tvalid, s_tlast, s_tready;
  logic [63:0]        m_tdata;
  logic [7:0]         m_tkeep;
  logic               m_tvalid, m_tlast, m_tready;
  logic [1:0]         grant_port;
  logic               busy, frame_start, trunc_err;
`ifdef ETH_ARB_PKT_CNT_EN
  logic [NP*32-1:0]   pkt_count;
`endif

  always #5 clk = ~clk;

  eth_rx_port_arbiter #(.NUM_PORTS(NP), .MAX_PKT_BEATS(MAXB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .grant_port    (grant_port),
    .busy          (busy),
    .frame_start   (frame_start),
    .trunc_err     (trunc_err)
`ifdef ETH_ARB_PKT_CNT_EN
    ,
    .pkt_count     (pkt_count)
`endif
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  beat_t       src[NP][32];
  int          src_n[NP], src_rd[NP];
  logic [63:0] out_data[64];
  logic [7:0]  out_keep[64];
  logic        out_last[64];
  int          out_port[64], out_cyc[64];
  int          out_n, fs_n, te_n, te_cyc, cyc;
  int          fs_port[16];
  int          checks = 0, failures = 0;
  bit          toggle_rdy, chk_rdy;

  function automatic logic [63:0] mk(int p, int f, int b);
    return {8'(p), 8'(f), 8'(b), 40'h0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input int p, input int f, input int n, input logic [7:0] lastkeep);
    for (int b = 0; b < n; b++) begin
      src[p][src_n[p]].data = mk(p, f, b);
      src[p][src_n[p]].keep = (b == n - 1) ? lastkeep : 8'hFF;
      src[p][src_n[p]].last = (b == n - 1);
      src_n[p]++;
    end
  endtask

  task automatic clear_logs();
    out_n = 0; fs_n = 0; te_n = 0; te_cyc = -1; cyc = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      if (src_rd[i] < src_n[i]) begin
        s_tvalid[i]          = 1'b1;
        s_tdata[i*64 +: 64]  = src[i][src_rd[i]].data;
        s_tkeep[i*8 +: 8]    = src[i][src_rd[i]].keep;
        s_tlast[i]           = src[i][src_rd[i]].last;
      end else begin
        s_tvalid[i]          = 1'b0;
        s_tdata[i*64 +: 64]  = '0;
        s_tkeep[i*8 +: 8]    = '0;
        s_tlast[i]           = 1'b0;
      end
    end
    m_tready = toggle_rdy ? (cyc % 2 == 1) : 1'b1;
  endtask

  task automatic sample();
    if (m_tvalid && m_tready && out_n < 64) begin
      out_data[out_n] = m_tdata;
      out_keep[out_n] = m_tkeep;
      out_last[out_n] = m_tlast;
      out_port[out_n] = int'(grant_port);
      out_cyc[out_n]  = cyc;
      out_n++;
    end
    if (frame_start) begin
      if (fs_n < 16) fs_port[fs_n] = int'(grant_port);
      fs_n++;
    end
    if (trunc_err) begin
      te_n++;
      te_cyc = cyc;
    end
    if (chk_rdy && busy) begin
      chk("rdy_other_ports", 64'(s_tready & 4'b1101), 64'h0);
      chk("rdy_follows_m", 64'(s_tready[1]), 64'(m_tready));
    end
    for (int i = 0; i < NP; i++)
      if (s_tvalid[i] && s_tready[i]) src_rd[i]++;
    cyc++;
  endtask

  task automatic cycle();
    drive();
    #1;
    sample();
    @(negedge clk);
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NP; i++)
      if (src_rd[i] < src_n[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_idle(input string tag, input int maxc);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!(all_empty() && !busy) && n < maxc);
    chk(tag, 64'(all_empty() && !busy), 64'h1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NP; i++) begin src_n[i] = 0; src_rd[i] = 0; end
    toggle_rdy = 1'b0;
    chk_rdy    = 1'b0;
    drive();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
  endtask

  initial begin
    s_tdata = '0; s_tkeep = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;
    toggle_rdy = 1'b0; chk_rdy = 1'b0;
    clear_logs();
    for (int i = 0; i < NP; i++) begin src_n[i] = 0; src_rd[i] = 0; end

    // Reset state
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_s_tready", 64'(s_tready), 64'h0);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'h0);
    chk("rst_grant", 64'(grant_port), 64'h0);
    chk("rst_frame_start", 64'(frame_start), 64'h0);
    chk("rst_trunc_err", 64'(trunc_err), 64'h0);
    @(negedge clk);

    // Ports 0 and 2, 3-beat frames each
    do_reset();
    push_frame(0, 0, 3, 8'hFF);
    push_frame(2, 0, 3, 8'hFF);
    run_idle("t1_done", 40);
    chk("t1_beats", 64'(out_n), 64'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t1_port%0d", i), 64'(out_port[i]), (i < 3) ? 64'd0 : 64'd2);
      chk($sformatf("t1_data%0d", i), out_data[i], mk((i < 3) ? 0 : 2, 0, i % 3));
      chk($sformatf("t1_last%0d", i), 64'(out_last[i]), 64'(i % 3 == 2));
    end
    chk("t1_fs_count", 64'(fs_n), 64'd2);
    chk("t1_fs_port0", 64'(fs_port[0]), 64'd0);
    chk("t1_fs_port1", 64'(fs_port[1]), 64'd2);
    chk("t1_first_beat_cyc", 64'(out_cyc[0]), 64'd1);
    chk("t1_bubble", 64'(out_cyc[3] - out_cyc[2]), 64'd2);

    // All four ports, two 2-beat frames each
    do_reset();
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < NP; p++) push_frame(p, f, 2, 8'hFF);
    run_idle("t2_done", 80);
    chk("t2_fs_count", 64'(fs_n), 64'd8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("t2_grant%0d", k), 64'(fs_port[k]), 64'(k % 4));
    for (int i = 0; i < 16; i++)
      chk($sformatf("t2_data%0d", i), out_data[i], mk((i / 2) % 4, i / 8, i % 2));

    // Port 1, 5-beat frame (exactly the beat limit) with toggling m_tready
    do_reset();
    toggle_rdy = 1'b1;
    chk_rdy    = 1'b1;
    push_frame(1, 0, 5, 8'h0F);
    run_idle("t3_done", 40);
    toggle_rdy = 1'b0;
    chk_rdy    = 1'b0;
    chk("t3_beats", 64'(out_n), 64'd5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_data%0d", i), out_data[i], mk(1, 0, i));
      chk($sformatf("t3_keep%0d", i), 64'(out_keep[i]), (i == 4) ? 64'h0F : 64'hFF);
      chk($sformatf("t3_last%0d", i), 64'(out_last[i]), 64'(i == 4));
    end
    chk("t3_last_cyc", 64'(out_cyc[4]), 64'd9);
    chk("t3_no_trunc", 64'(te_n), 64'd0);

    // Port 3, 7-beat frame: truncated at beat 5, rest re-arbitrated
    do_reset();
    push_frame(3, 0, 7, 8'hFF);
    run_idle("t4_done", 40);
    chk("t4_beats", 64'(out_n), 64'd7);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("t4_data%0d", i), out_data[i], mk(3, 0, i));
      chk($sformatf("t4_last%0d", i), 64'(out_last[i]), 64'(i == 4 || i == 6));
    end
    chk("t4_trunc_count", 64'(te_n), 64'd1);
    chk("t4_trunc_cyc", 64'(te_cyc), 64'(out_cyc[4] + 1));
    chk("t4_fs_count", 64'(fs_n), 64'd2);
    chk("t4_rearb_bubble", 64'(out_cyc[5] - out_cyc[4]), 64'd2);

    // Reset during beat 2 of a port 1 frame
    do_reset();
    push_frame(0, 0, 2, 8'hFF);
    push_frame(1, 0, 4, 8'hFF);
    for (int n = 0; n < 30 && out_n < 3; n++) cycle();
    chk("t5_reached_beat2", 64'(out_n), 64'd3);
    drive();
    #1;
    chk("t5_busy_before", 64'(busy), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("t5_busy_async", 64'(busy), 64'h0);
    chk("t5_s_tready_async", 64'(s_tready), 64'h0);
    chk("t5_m_tvalid_async", 64'(m_tvalid), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    push_frame(0, 1, 2, 8'hFF);
    run_idle("t5_done", 40);
    chk("t5_fs_count", 64'(fs_n), 64'd2);
    chk("t5_first_grant", 64'(fs_port[0]), 64'd0);
    chk("t5_second_grant", 64'(fs_port[1]), 64'd1);
    chk("t5_beats", 64'(out_n), 64'd5);
    chk("t5_data0", out_data[0], mk(0, 1, 0));
    chk("t5_data2", out_data[2], mk(1, 0, 1));
    chk("t5_data4", out_data[4], mk(1, 0, 3));
    chk("t5_last4", 64'(out_last[4]), 64'h1);

`ifdef ETH_ARB_PKT_CNT_EN
    // Frame counters: three frames on port 2, one on port 0
    do_reset();
    for (int f = 0; f < 3; f++) push_frame(2, f, 1, 8'hFF);
    push_frame(0, 0, 1, 8'hFF);
    run_idle("t6_done", 40);
    chk("t6_cnt_p0", 64'(pkt_count[0*32 +: 32]), 64'd1);
    chk("t6_cnt_p1", 64'(pkt_count[1*32 +: 32]), 64'd0);
    chk("t6_cnt_p2", 64'(pkt_count[2*32 +: 32]), 64'd3);
    chk("t6_cnt_p3", 64'(pkt_count[3*32 +: 32]), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/eth_rx_port_arbiter.md
Name: eth_rx_port_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one ethernet header parser between NUM_PORTS 64-bit AXI-Stream receive ports.
- Holds a grant for a whole frame, from first beat to tlast, so the parser's word-position state machine never sees interleaved frames.
- Sits between the per-port MAC receive FIFOs and the parser's s_axis interface.
- Reports which port owns the current frame so downstream logic can tag the parsed header fields.

Parameters:
- NUM_PORTS, 4, number of requesting input streams (2..8).
- PORT_W, $clog2(NUM_PORTS), width of the port index.
- MAX_PKT_BEATS, 256, beat limit; reaching it forces end of grant.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- s_axis_tdata  in  NUM_PORTS*64  per-port data; port i at [i*64 +: 64]
- s_axis_tkeep  in  NUM_PORTS*8  per-port byte enables
- s_axis_tvalid  in  NUM_PORTS  per-port valid
- s_axis_tlast  in  NUM_PORTS  per-port last
- s_axis_tready  out  NUM_PORTS  per-port ready
- m_axis_tdata  out  64  data to parser
- m_axis_tkeep  out  8  keep to parser
- m_axis_tvalid  out  1  valid to parser
- m_axis_tlast  out  1  last to parser
- m_axis_tready  in  1  ready from parser
- grant_port  out  PORT_W  index of the owning port; valid while busy=1
- busy  out  1  a frame is in progress
- frame_start  out  1  one-cycle pulse in the cycle the grant is taken
- trunc_err  out  1  one-cycle pulse when MAX_PKT_BEATS forces termination

Behaviour:
- Reset: state=IDLE, rr_ptr=0, grant_port=0, busy=0, frame_start=0, trunc_err=0, beat_cnt=0.
- Reset: s_axis_tready all 0, m_axis_tvalid=0.
- Reset asserted mid-frame drops the grant immediately; the remainder of that frame is re-arbitrated as a new frame. This is the upstream's responsibility.
- State IDLE:
  - If any s_axis_tvalid[i]=1, select the first requesting port at or after rr_ptr, cyclically.
  - Register it into grant_port, set busy=1, pulse frame_start, go to FWD.
  - No data moves in IDLE: one bubble cycle per frame.
- State FWD (datapath is combinational from the registered grant):
  - m_axis_tdata/tkeep/tvalid/tlast = the selected port's signals.
  - s_axis_tready[grant_port] = m_axis_tready; every other ready = 0.
  - beat_cnt increments on each m_axis handshake.
- End of frame:
  - On a handshake with tlast=1: go to IDLE, busy=0, rr_ptr = grant_port+1, wrapping NUM_PORTS-1 -> 0, beat_cnt=0.
- Forced end of frame:
  - If a handshake occurs with beat_cnt==MAX_PKT_BEATS-1 and tlast=0: force m_axis_tlast=1 on that beat, pulse trunc_err, and return to IDLE as for a normal end.
  - The source's remaining beats arrive later as a new frame.
- Idle output: m_axis_tvalid=0 whenever busy=0. m_axis_tdata/tkeep hold the selected-port mux value and are don't-care.
- Source bubbles: s_axis_tvalid low mid-frame holds the grant indefinitely (no timeout).
- Simultaneous requests: round-robin order only. A port that just finished has lowest priority next cycle.
- Single requester: the same port is re-granted after one idle cycle.
- AXI rules: the arbiter never drops m_axis_tvalid without a handshake while in FWD and the source holds valid. tkeep is passed unchanged.

Optional Feature:
- Macro ETH_ARB_PKT_CNT_EN.
- Defined:
  - Adds output pkt_count of width NUM_PORTS*32: per-port count of completed frames, incremented on each end-of-frame (normal or truncated) for grant_port.
  - Wraps at 2^32; reset to 0.
- Undefined: port and counters absent; no other change.

Decomposition:
- Shared package eth_pkg:
  - AXIS_DATA_W=64, AXIS_KEEP_W=8.
  - Arbiter state enum {IDLE, FWD}.
  - Ethertype constants shared with the parser.
- Sub-module rr_pick: combinational rotate-priority encoder with inputs req[NUM_PORTS] and ptr, outputs idx and any. Reusable by the TX-side scheduler.

Test Plan:
- Ports 0 and 2 each present a 3-beat frame at t0, rr_ptr=0 -> port 0 frame, one idle cycle, port 2 frame; grant_port 0 then 2; frame_start pulses twice; no beat interleaving.
- All 4 ports request continuously with 2-beat frames -> grant sequence 0,1,2,3,0; every port receives one grant per 4 frames.
- m_axis_tready toggles 1,0,1,0 during a 5-beat port 1 frame -> only s_axis_tready[1] follows m_axis_tready; all 5 beats delivered in order with unchanged tkeep (last beat tkeep=0x0F).
- MAX_PKT_BEATS=4 with a 6-beat frame on port 3 -> beat 4 forwarded with m_axis_tlast=1 and trunc_err pulse; beats 5-6 emerge as a new frame after re-arbitration.
- rst_n asserted on beat 2 of a port 1 frame -> busy=0, all s_axis_tready=0, m_axis_tvalid=0 asynchronously; after release rr_ptr=0, so port 0 wins if requesting.
- ETH_ARB_PKT_CNT_EN defined: 3 frames on port 2 and 1 on port 0 -> pkt_count port 2 = 3, port 0 = 1, others 0.
